// File: rtl/calc_pkg.sv
// Calculator block package: widths, FSM state encoding and shared types.
package calc_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned WORD_W = 2 * DATA_W;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_A,
      S_READ_B,
      S_ADD,
      S_WRITE,
      S_END
   } state_t;

endpackage

// File: rtl/calc_if.sv
// Single-bank SRAM access bus: the controller is master, the bank model is slave.
interface calc_if;

   logic [calc_pkg::ADDR_W-1:0] addr;
   logic                        we;
   logic [calc_pkg::DATA_W-1:0] wdata;
   logic [calc_pkg::DATA_W-1:0] rdata;

   modport master (output addr, we, wdata, input rdata);
   modport slave  (input addr, we, wdata, output rdata);

endinterface

// File: rtl/calc_ctrl.sv
// Calculator controller: FSM, read/write pointers, operand register, 64-bit
// adder and SRAM address/strobe generation for both banks.
// Optional feature macro: CALC_CYCLE_COUNT_EN (adds cycle_count).
module calc_ctrl
   import calc_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  addr_t         read_start_addr,
   input  addr_t         read_end_addr,
   input  addr_t         write_start_addr,
   input  addr_t         write_end_addr,
   output addr_t         w_addr,
   calc_if.master        bus_a,
   calc_if.master        bus_b
);

   // Read pointer carries one spare bit so a window ending at the top word cannot wrap.
   localparam int unsigned RPTR_W = ADDR_W + 1;

   state_t            state;
   logic [RPTR_W-1:0] r_addr_q;
   addr_t             w_addr_q;
   addr_t             rd_end_q;
   addr_t             wr_end_q;
   word_t             op_a_q;
   logic              b_valid_q;
   addr_t             addr_q;
   logic              we_q;
   word_t             wdata_q;

   word_t             b_word_c;
   word_t             sum_c;
   logic              rd_more_c;

   // Operand B is zero when the read window had an odd length.
   always_comb begin
      b_word_c  = '0;
      if (b_valid_q) begin
         b_word_c = {bus_b.rdata, bus_a.rdata};
      end
      sum_c     = op_a_q + b_word_c;
      rd_more_c = (r_addr_q <= {1'b0, rd_end_q});
   end

   // Sequencer: one result per READ_A -> READ_B -> ADD -> WRITE pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         r_addr_q  <= '0;
         w_addr_q  <= '0;
         rd_end_q  <= '0;
         wr_end_q  <= '0;
         op_a_q    <= '0;
         b_valid_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               r_addr_q <= RPTR_W'(read_start_addr);
               w_addr_q <= write_start_addr;
               rd_end_q <= read_end_addr;
               wr_end_q <= write_end_addr;
               addr_q   <= read_start_addr;
               if ((read_start_addr > read_end_addr) || (write_start_addr > write_end_addr)) begin
                  state <= S_END;
               end else begin
                  state <= S_READ_A;
               end
            end
            S_READ_A: begin
               r_addr_q <= r_addr_q + RPTR_W'(1);
               addr_q   <= ADDR_W'(r_addr_q + RPTR_W'(1));
               state    <= S_READ_B;
            end
            S_READ_B: begin
               op_a_q <= {bus_b.rdata, bus_a.rdata};
               if (rd_more_c) begin
                  r_addr_q  <= r_addr_q + RPTR_W'(1);
                  b_valid_q <= 1'b1;
               end else begin
                  b_valid_q <= 1'b0;
               end
               state <= S_ADD;
            end
            S_ADD: begin
               wdata_q <= sum_c;
               addr_q  <= w_addr_q;
               we_q    <= 1'b1;
               state   <= S_WRITE;
            end
            S_WRITE: begin
               we_q <= 1'b0;
               if ((w_addr_q == wr_end_q) || !rd_more_c) begin
                  state <= S_END;
               end else begin
                  w_addr_q <= w_addr_q + ADDR_W'(1);
                  addr_q   <= ADDR_W'(r_addr_q);
                  state    <= S_READ_A;
               end
            end
            S_END: begin
               state <= S_END;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CALC_CYCLE_COUNT_EN
   logic [31:0] cycle_count;

   // Busy-cycle counter; frozen in S_END until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
      end else if ((state != S_IDLE) && (state != S_END)) begin
         cycle_count <= cycle_count + 32'd1;
      end
   end
`endif

   // Both banks share address and strobe; rst masks the strobe so an abort never lands a write.
   assign bus_a.addr  = addr_q;
   assign bus_b.addr  = addr_q;
   assign bus_a.we    = we_q & ~rst;
   assign bus_b.we    = we_q & ~rst;
   assign bus_a.wdata = wdata_q[DATA_W-1:0];
   assign bus_b.wdata = wdata_q[WORD_W-1:DATA_W];
   assign w_addr      = w_addr_q;

endmodule

// File: rtl/calc_sram.sv
// Behavioural single-port 1024x32 SRAM bank with 1-cycle synchronous read.
// Contents have no reset; they survive rst.
module calc_sram_mem
   import calc_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] memory [DEPTH];

   // Single port: a write cycle does not update the read register.
   always_ff @(posedge clk) begin
      if (we) begin
         memory[addr] <= wdata;
      end else begin
         rdata <= memory[addr];
      end
   end

endmodule

// Bus-facing wrapper around one bank array.
module calc_sram (
   input logic   clk,
   calc_if.slave bus
);

   calc_sram_mem memory_mode_inst (
      .clk   (clk),
      .we    (bus.we),
      .addr  (bus.addr),
      .wdata (bus.wdata),
      .rdata (bus.rdata)
   );

endmodule

// File: rtl/calc_top.sv
// Calculator top: memory-to-memory 64-bit pairwise adder over two 32-bit SRAM banks.
// Optional feature macro: CALC_CYCLE_COUNT_EN (busy-cycle counter in u_ctrl).
module calc_top
   import calc_pkg::*;
(
   input logic              clk,
   input logic              rst,
   input logic [ADDR_W-1:0] read_start_addr,
   input logic [ADDR_W-1:0] read_end_addr,
   input logic [ADDR_W-1:0] write_start_addr,
   input logic [ADDR_W-1:0] write_end_addr
);

   calc_if bus_a ();
   calc_if bus_b ();

   logic [ADDR_W-1:0] w_addr;

   calc_ctrl u_ctrl (
      .clk              (clk),
      .rst              (rst),
      .read_start_addr  (read_start_addr),
      .read_end_addr    (read_end_addr),
      .write_start_addr (write_start_addr),
      .write_end_addr   (write_end_addr),
      .w_addr           (w_addr),
      .bus_a            (bus_a),
      .bus_b            (bus_b)
   );

   calc_sram sram_A (
      .clk (clk),
      .bus (bus_a)
   );

   calc_sram sram_B (
      .clk (clk),
      .bus (bus_b)
   );

   // Every bank write must land on the current result pointer.
   write_at_w_addr: assert property (@(posedge clk) disable iff (rst)
      bus_a.we |-> (bus_a.addr == w_addr));

endmodule

// File: tb/tb_calc_top.sv
// Bench for calc_top: SRAM preload, expected-write scoreboard, final memory dump.
// Cycle counter checks are active when CALC_CYCLE_COUNT_EN is defined.
module tb_calc_top;
   import calc_pkg::*;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [63:0]       data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] rs = '0, re = '0, ws = '0, wend = '0;

   exp_t        exp_q[$];
   logic [63:0] model[DEPTH];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   calc_top dut (
      .clk              (clk),
      .rst              (rst),
      .read_start_addr  (rs),
      .read_end_addr    (re),
      .write_start_addr (ws),
      .write_end_addr   (wend)
   );

   // Observation copy of the bank-A bus.
   calc_if mon_if ();
   assign mon_if.addr  = dut.bus_a.addr;
   assign mon_if.we    = dut.bus_a.we;
   assign mon_if.wdata = dut.bus_a.wdata;
   assign mon_if.rdata = dut.bus_a.rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return {(32'h9E37_79B9 * kk) ^ 32'h5A5A_0000, 32'hC000_0000 + (32'h0246_8ACF * kk)};
   endfunction

   task automatic poke(input int a, input logic [63:0] v);
      model[a] = v;
      dut.sram_A.memory_mode_inst.memory[a] = v[31:0];
      dut.sram_B.memory_mode_inst.memory[a] = v[63:32];
   endtask

   task automatic preload();
      for (int i = 0; i < int'(DEPTH); i++) poke(i, pat(i));
   endtask

   task automatic expect_write(input int a, input logic [63:0] v);
      exp_t e;
      e.addr = ADDR_W'(a);
      e.data = v;
      exp_q.push_back(e);
      model[a] = v;
   endtask

   // Expected result stream for a non-overlapping read/write window pair.
   task automatic build_expected(input int r0, input int r1, input int w0, input int w1);
      int r = r0;
      int w = w0;
      logic [63:0] b;
      forever begin
         b = (r + 1 <= r1) ? model[r + 1] : 64'd0;
         expect_write(w, model[r] + b);
         r += 2;
         if (w == w1 || r > r1) break;
         w++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
      check("reset_w_addr", 64'(dut.w_addr), 64'd0);
   endtask

   task automatic start(input int r0, input int r1, input int w0, input int w1);
      rs   = ADDR_W'(r0);
      re   = ADDR_W'(r1);
      ws   = ADDR_W'(w0);
      wend = ADDR_W'(w1);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_end(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (dut.u_ctrl.state == S_END) break;
         @(posedge clk);
         #1;
      end
      check({name, "_end_state"}, 64'(dut.u_ctrl.state), 64'(S_END));
      @(negedge clk);
      check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic dump_check(input string name);
      int bad = 0;
      logic [63:0] got;
      for (int i = 0; i < int'(DEPTH); i++) begin
         got = {dut.sram_B.memory_mode_inst.memory[i], dut.sram_A.memory_mode_inst.memory[i]};
         if (got !== model[i]) begin
            if (bad == 0) $display("FAIL %s_first_bad addr=%0d got %h expected %h", name, i, got, model[i]);
            bad++;
         end
      end
      check({name, "_mem_dump_bad_words"}, 64'(bad), 64'd0);
   endtask

   // Scoreboard monitor: every observed write pops and compares the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [63:0] got;
      if (mon_if.we === 1'b1) begin
         got = {dut.bus_b.wdata, mon_if.wdata};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h", mon_if.addr, got);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 64'(mon_if.addr), 64'(e.addr));
            check("write_data", got, e.data);
         end
      end
   end

   initial begin
      // Scenario 1: full default run.
      do_reset();
      preload();
      build_expected(0, 511, 768, 1023);
      start(0, 511, 768, 1023);
      wait_end("s1", 3000);
      check("s1_final_w_addr", 64'(dut.w_addr), 64'd1023);
`ifdef CALC_CYCLE_COUNT_EN
      check("s1_cycle_count", 64'(dut.u_ctrl.cycle_count), 64'd1024);
`endif
      dump_check("s1");

      // Scenario 2: carry from bank A into bank B.
      do_reset();
      preload();
      poke(0, 64'h0000_0000_FFFF_FFFF);
      poke(1, 64'h0000_0000_0000_0001);
      expect_write(768, 64'h0000_0001_0000_0000);
      start(0, 1, 768, 768);
      wait_end("s2", 100);
      dump_check("s2");

      // Scenario 3: 64-bit overflow wraps, carry out dropped.
      do_reset();
      preload();
      poke(0, 64'hFFFF_FFFF_FFFF_FFFF);
      poke(1, 64'hFFFF_FFFF_FFFF_FFFF);
      expect_write(768, 64'hFFFF_FFFF_FFFF_FFFE);
      start(0, 1, 768, 768);
      wait_end("s3", 100);
      dump_check("s3");

      // Scenario 4: odd read window, last operand paired with zero.
      do_reset();
      preload();
      poke(2, 64'd7);
      expect_write(100, pat(0) + pat(1));
      expect_write(101, 64'd7);
      start(0, 2, 100, 101);
      wait_end("s4", 100);
      check("s4_mem102_untouched",
            {dut.sram_B.memory_mode_inst.memory[102], dut.sram_A.memory_mode_inst.memory[102]},
            pat(102));
      dump_check("s4");

      // Scenario 5: reset mid-run, then complete rerun.
      do_reset();
      preload();
      build_expected(0, 511, 768, 1023);
      start(0, 511, 768, 1023);
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("s5_abort_state", 64'(dut.u_ctrl.state), 64'(S_IDLE));
      check("s5_abort_w_addr", 64'(dut.w_addr), 64'd0);
      exp_q.delete();
      build_expected(0, 511, 768, 1023);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      wait_end("s5", 3000);
`ifdef CALC_CYCLE_COUNT_EN
      check("s5_cycle_count", 64'(dut.u_ctrl.cycle_count), 64'd1024);
`endif
      dump_check("s5");

      // Scenario 6: inverted write window ends immediately with no writes.
      do_reset();
      preload();
      start(0, 511, 10, 5);
      @(posedge clk);
      #1;
      check("s6_end_next_cycle", 64'(dut.u_ctrl.state), 64'(S_END));
      repeat (20) @(posedge clk);
      #1;
      check("s6_still_end", 64'(dut.u_ctrl.state), 64'(S_END));
`ifdef CALC_CYCLE_COUNT_EN
      check("s6_cycle_count", 64'(dut.u_ctrl.cycle_count), 64'd0);
`endif
      dump_check("s6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
